// File: rtl/icache_loader_if.sv
// ---------------------------------------------------------------------------
// icache_loader_if -- byte-source / icache-write bundle for icache_loader.
//
// Signals
//   in_start        1   one-cycle pulse that begins a load session
//   in_byte_valid   1   source byte valid
//   in_byte         8   source byte, MSB-first within each 32-bit word
//   out_byte_ready  1   loader accepts in_byte this cycle
//   out_we          1   icache write strobe, one cycle per word
//   out_waddr       8   icache word address (same index as PC[9:2])
//   out_wdata       32  icache write data
//   out_cpu_hold    1   holds the IF stage while loading
//   out_done        1   session complete (level)
//   out_err         1   checksum mismatch (level)
//
// Modports
//   master : byte source / controller side (drives in_*)
//   slave  : the loader (drives out_*)
// ---------------------------------------------------------------------------
interface icache_loader_if;
  logic        in_start;
  logic        in_byte_valid;
  logic [7:0]  in_byte;
  logic        out_byte_ready;
  logic        out_we;
  logic [7:0]  out_waddr;
  logic [31:0] out_wdata;
  logic        out_cpu_hold;
  logic        out_done;
  logic        out_err;

  modport master (
    output in_start, in_byte_valid, in_byte,
    input  out_byte_ready, out_we, out_waddr, out_wdata,
           out_cpu_hold, out_done, out_err
  );

  modport slave (
    input  in_start, in_byte_valid, in_byte,
    output out_byte_ready, out_we, out_waddr, out_wdata,
           out_cpu_hold, out_done, out_err
  );
endinterface

// File: rtl/icache_loader.sv
// ---------------------------------------------------------------------------
// icache_loader -- streams bytes from a source into the instruction cache.
//
// Bytes arrive MSB-first, four per word. Each assembled word is written to
// the icache with a single-cycle out_we at word index 0..WORD_COUNT-1. The
// CPU fetch stage is held from reset until the session completes.
//
// Parameters
//   WORD_COUNT  words loaded per session (1..256)
//
// Ports
//   in_clk   sole clock, rising edge
//   in_rst   synchronous, active-high reset
//   bus      icache_loader_if.slave (byte source in, icache write out,
//            cpu hold / done / err status)
//
// Build option
//   ICACHE_LOADER_CHECKSUM_EN  when defined, a running XOR of every data byte
//   is kept and one extra byte is accepted after the last word; out_err is
//   set if that byte differs from the XOR. When undefined there is no
//   checksum state and out_err is tied low.
// ---------------------------------------------------------------------------
module icache_loader #(
  parameter int WORD_COUNT = 256
) (
  input logic            in_clk,
  input logic            in_rst,
  icache_loader_if.slave bus
);

`ifdef ICACHE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

  // Index of the final word; the address counter stops here, so a full
  // 256-word load ends at 255 without wrapping back to 0.
  localparam logic [7:0] LAST_IDX = 8'(WORD_COUNT - 1);

  state_t      state_q, state_d;
  logic [7:0]  idx_q;
  logic [1:0]  cnt_q;
  logic [31:0] shift_q;

  logic ready;
  logic we;
  logic start_sess;
  logic load_acc;
  logic advance;

`ifdef ICACHE_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       err_q;
  logic       chk_acc;
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of its neighbours regardless of process order.
  always_ff @(posedge in_clk) begin
    if (in_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    we         = 1'b0;
    start_sess = 1'b0;
    load_acc   = 1'b0;
    advance    = 1'b0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
    chk_acc    = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.in_start) begin
          start_sess = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        ready    = 1'b1;
        load_acc = bus.in_byte_valid;
        if (bus.in_byte_valid && cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        we = 1'b1;
        if (idx_q == LAST_IDX) begin
`ifdef ICACHE_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          advance = 1'b1;
          state_d = LOAD;
        end
      end
`ifdef ICACHE_LOADER_CHECKSUM_EN
      CHK: begin
        ready   = 1'b1;
        chk_acc = bus.in_byte_valid;
        if (bus.in_byte_valid) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath: word index, byte counter, assembly shift register and,
  // optionally, the running checksum. A reset mid-session drops the partial
  // word; earlier words are already in the icache and stay there.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      if (start_sess) begin
        idx_q  <= '0;
        cnt_q  <= '0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        csum_q <= '0;
        err_q  <= 1'b0;
`endif
      end
      if (load_acc) begin
        shift_q <= {shift_q[23:0], bus.in_byte};
        cnt_q   <= cnt_q + 2'd1;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        csum_q  <= csum_q ^ bus.in_byte;
`endif
      end
      if (advance) idx_q <= idx_q + 8'd1;
`ifdef ICACHE_LOADER_CHECKSUM_EN
      if (chk_acc) err_q <= (bus.in_byte != csum_q);
`endif
    end
  end

  assign bus.out_byte_ready = ready;
  assign bus.out_we         = we;
  assign bus.out_waddr      = idx_q;
  assign bus.out_wdata      = shift_q;
  assign bus.out_cpu_hold   = (state_q != DONE);
  assign bus.out_done       = (state_q == DONE);
`ifdef ICACHE_LOADER_CHECKSUM_EN
  assign bus.out_err        = err_q;
`else
  assign bus.out_err        = 1'b0;
`endif

endmodule

// File: tb/tb_icache_loader.sv
// ---------------------------------------------------------------------------
// tb_icache_loader -- directed bench for icache_loader.
//
// Three loaders (WORD_COUNT 2, 4, 256; plus 1 when the checksum build option
// is defined) share the byte source and reset. in_start goes only to the
// loader picked by sel, and the observed outputs are muxed from that loader.
// Loaders that are idle or done must ignore the shared byte stream.
// ---------------------------------------------------------------------------
module tb_icache_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] byte_d = 8'h00;
  int         sel = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  icache_loader_if if2 ();
  icache_loader_if if4 ();
  icache_loader_if if256 ();

  assign if2.in_start        = start && (sel == 0);
  assign if2.in_byte_valid   = valid;
  assign if2.in_byte         = byte_d;
  assign if4.in_start        = start && (sel == 1);
  assign if4.in_byte_valid   = valid;
  assign if4.in_byte         = byte_d;
  assign if256.in_start      = start && (sel == 2);
  assign if256.in_byte_valid = valid;
  assign if256.in_byte       = byte_d;

  icache_loader #(.WORD_COUNT(2))   u_wc2   (.in_clk(clk), .in_rst(rst), .bus(if2));
  icache_loader #(.WORD_COUNT(4))   u_wc4   (.in_clk(clk), .in_rst(rst), .bus(if4));
  icache_loader #(.WORD_COUNT(256)) u_wc256 (.in_clk(clk), .in_rst(rst), .bus(if256));

`ifdef ICACHE_LOADER_CHECKSUM_EN
  icache_loader_if if1 ();
  assign if1.in_start      = start && (sel == 3);
  assign if1.in_byte_valid = valid;
  assign if1.in_byte       = byte_d;
  icache_loader #(.WORD_COUNT(1)) u_wc1 (.in_clk(clk), .in_rst(rst), .bus(if1));
`endif

  // Observed outputs of the selected loader.
  logic        m_ready, m_we, m_hold, m_done, m_err;
  logic [7:0]  m_waddr;
  logic [31:0] m_wdata;

  always_comb begin
    m_ready = if2.out_byte_ready; m_we = if2.out_we; m_waddr = if2.out_waddr;
    m_wdata = if2.out_wdata; m_hold = if2.out_cpu_hold; m_done = if2.out_done;
    m_err   = if2.out_err;
    case (sel)
      1: begin
        m_ready = if4.out_byte_ready; m_we = if4.out_we; m_waddr = if4.out_waddr;
        m_wdata = if4.out_wdata; m_hold = if4.out_cpu_hold; m_done = if4.out_done;
        m_err   = if4.out_err;
      end
      2: begin
        m_ready = if256.out_byte_ready; m_we = if256.out_we; m_waddr = if256.out_waddr;
        m_wdata = if256.out_wdata; m_hold = if256.out_cpu_hold; m_done = if256.out_done;
        m_err   = if256.out_err;
      end
`ifdef ICACHE_LOADER_CHECKSUM_EN
      3: begin
        m_ready = if1.out_byte_ready; m_we = if1.out_we; m_waddr = if1.out_waddr;
        m_wdata = if1.out_wdata; m_hold = if1.out_cpu_hold; m_done = if1.out_done;
        m_err   = if1.out_err;
      end
`endif
      default: ;
    endcase
  end

  // Write log of the selected loader, sampled mid-cycle.
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          we_ready_clash = 0;

  always @(negedge clk) begin
    if (!rst && m_we) begin
      wr_addr.push_back(m_waddr);
      wr_data.push_back(m_wdata);
      if (m_ready) we_ready_clash++;
    end
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    we_ready_clash = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one byte and hold it until the loader accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    valid  = 1'b1;
    byte_d = b;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL send_byte_timeout: byte %02h never accepted after %0d cycles (required within 20)", b, n);
    end
    @(posedge clk);
  endtask

  task automatic idle_gap();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    valid = 1'b0;
    while (!m_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (m_done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done_timeout: out_done=%b after %0d cycles, required 1", name, m_done, n);
    end
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if ({m_ready, m_we, m_waddr, m_wdata, m_hold, m_done, m_err} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL %s: ready=%b we=%b waddr=%02h wdata=%08h hold=%b done=%b err=%b, required 0 0 00 00000000 1 0 0",
               name, m_ready, m_we, m_waddr, m_wdata, m_hold, m_done, m_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_reset_values($sformatf("reset_values_sel%0d", s));
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sel = 0;
    #1;
    check_reset_values("idle_after_release");
  endtask

  // Shared by the continuous and gapped variants of the two-word load.
  task automatic run_two_words(input string name, input bit gapped);
    logic [7:0] bytes [8];
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sel = 0;
    clear_log();
    pulse_start();
    tests++;
    if (m_hold !== 1'b1 || m_done !== 1'b0) begin
      fails++;
      $display("FAIL %s_hold_in_load: hold=%b done=%b, required 1 0", name, m_hold, m_done);
    end
    for (int i = 0; i < 8; i++) begin
      if (gapped) idle_gap();
      send_byte(bytes[i]);
    end
    wait_done(name, 20);
    tests++;
    if (wr_addr.size() !== 2) begin
      fails++;
      $display("FAIL %s_write_count: %0d writes, required 2", name, wr_addr.size());
    end else begin
      tests++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h12345678) begin
        fails++;
        $display("FAIL %s_word0: addr=%0d data=%08h, required 0 12345678", name, wr_addr[0], wr_data[0]);
      end
      tests++;
      if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'hAABBCCDD) begin
        fails++;
        $display("FAIL %s_word1: addr=%0d data=%08h, required 1 aabbccdd", name, wr_addr[1], wr_data[1]);
      end
    end
    tests++;
    if (m_done !== 1'b1 || m_hold !== 1'b0 || m_err !== 1'b0) begin
      fails++;
      $display("FAIL %s_final: done=%b hold=%b err=%b, required 1 0 0", name, m_done, m_hold, m_err);
    end
    tests++;
    if (we_ready_clash !== 0) begin
      fails++;
      $display("FAIL %s_ready_in_write: ready high in %0d write cycles, required 0", name, we_ready_clash);
    end
  endtask

  task automatic test_continuous();
    run_two_words("continuous", 1'b0);
  endtask

  task automatic test_gapped();
    run_two_words("gapped", 1'b1);
  endtask

  // Bytes offered while DONE must not be taken and must not restart anything.
  task automatic test_ignore_valid_in_done();
    sel = 0;
    clear_log();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid  = 1'b1;
      byte_d = 8'h5A;
      tests++;
      if (m_ready !== 1'b0 || m_done !== 1'b1) begin
        fails++;
        $display("FAIL done_ignores_valid: ready=%b done=%b, required 0 1", m_ready, m_done);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    tests++;
    if (wr_addr.size() !== 0) begin
      fails++;
      $display("FAIL done_no_write: %0d writes, required 0", wr_addr.size());
    end
  endtask

  task automatic test_reset_mid_session();
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sel = 1;
    clear_log();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
    @(negedge clk);
    valid = 1'b0;
    tests++;
    if (wr_addr.size() !== 1 || wr_data[0] !== 32'h11223344) begin
      fails++;
      $display("FAIL midreset_first_word: %0d writes, required 1 of 11223344", wr_addr.size());
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values("midreset_outputs");
    rst = 1'b0;
    clear_log();
    pulse_start();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    repeat (2) @(negedge clk);
    valid = 1'b0;
    tests++;
    if (wr_addr.size() < 1) begin
      fails++;
      $display("FAIL midreset_restart_count: 0 writes, required at least 1");
    end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hA1A2A3A4) begin
      fails++;
      $display("FAIL midreset_restart_word: addr=%0d data=%08h, required 0 a1a2a3a4", wr_addr[0], wr_data[0]);
    end
  endtask

  // Full 256-word load with a stray start pulse during LOAD.
  task automatic test_full_load_with_start();
    int bad = 0;
    sel = 2;
    clear_log();
    pulse_start();
    for (int i = 0; i < 1024; i++) begin
      send_byte(pat(i));
      if (i == 4) begin
        @(negedge clk);
        valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (m_hold !== 1'b1 || m_done !== 1'b0 || m_ready !== 1'b1) begin
          fails++;
          $display("FAIL start_in_load: hold=%b done=%b ready=%b, required 1 0 1", m_hold, m_done, m_ready);
        end
      end
    end
    wait_done("full256", 20);
    repeat (5) @(negedge clk);
    tests++;
    if (wr_addr.size() !== 256) begin
      fails++;
      $display("FAIL full256_write_count: %0d writes, required 256", wr_addr.size());
    end else begin
      for (int k = 0; k < 256; k++)
        if (wr_addr[k] !== 8'(k) ||
            wr_data[k] !== {pat(4*k), pat(4*k+1), pat(4*k+2), pat(4*k+3)}) bad++;
      tests++;
      if (bad !== 0) begin
        fails++;
        $display("FAIL full256_contents: %0d wrong writes, required 0", bad);
      end
      tests++;
      if (wr_addr[255] !== 8'd255) begin
        fails++;
        $display("FAIL full256_last_addr: %0d, required 255", wr_addr[255]);
      end
    end
    tests++;
    if (m_hold !== 1'b0 || m_err !== 1'b0 || m_waddr !== 8'd255) begin
      fails++;
      $display("FAIL full256_final: hold=%b err=%b waddr=%0d, required 0 0 255", m_hold, m_err, m_waddr);
    end
  endtask

`ifdef ICACHE_LOADER_CHECKSUM_EN
  task automatic run_checksum(input logic [7:0] chk, input logic exp_err);
    sel = 3;
    clear_log();
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(chk);
    wait_done($sformatf("checksum_%02h", chk), 20);
    tests++;
    if (m_err !== exp_err || m_done !== 1'b1) begin
      fails++;
      $display("FAIL checksum_%02h: err=%b done=%b, required %b 1", chk, m_err, m_done, exp_err);
    end
    tests++;
    if (wr_addr.size() !== 1 || wr_data[0] !== 32'h01020304) begin
      fails++;
      $display("FAIL checksum_%02h_write: %0d writes, required 1 of 01020304", chk, wr_addr.size());
    end
  endtask

  task automatic test_checksum();
    run_checksum(8'h04, 1'b0);
    run_checksum(8'h05, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_ignore_valid_in_done();
    test_gapped();
    test_reset_mid_session();
    test_full_load_with_start();
`ifdef ICACHE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at 2 ms, required to finish");
    $fatal(1, "global timeout");
  end

endmodule
